// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and defaults for the BTB write-side update controller.
package btb_update_ctrl_pkg;

    localparam int unsigned XLEN                   = 32;
    localparam int unsigned BTB_UPDATE_QUEUE_DEPTH = 8;
    localparam int unsigned N                      = 2;

    typedef logic [XLEN-1:0] ADDR;

    typedef struct packed {
        ADDR pc;
        ADDR target;
    } BTB_UPDATE_ENTRY;

endpackage

// File: rtl/btb_upd_match.sv
// Combinational CAM: finds the occupied queue entry whose PC equals the lookup PC.
module btb_upd_match
    import btb_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = BTB_UPDATE_QUEUE_DEPTH
)(
    input  ADDR                        entry_pc [DEPTH],
    input  logic [DEPTH-1:0]           valid_mask,
    input  ADDR                        lookup_pc,
    output logic                       hit,
    output logic [$clog2(DEPTH)-1:0]   hit_idx
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Queue holds unique PCs among matchable entries, so at most one slot hits
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (valid_mask[j] && (entry_pc[j] == lookup_pc)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Collects retire-lane BTB updates, dedups and coalesces them, and drains
// one write per cycle onto the BTB's single write port.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH  = BTB_UPDATE_QUEUE_DEPTH,
    parameter int unsigned UPDATE_WIDTH = N
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [UPDATE_WIDTH-1:0]       upd_valid,
    input  ADDR  [UPDATE_WIDTH-1:0]       upd_pc,
    input  ADDR  [UPDATE_WIDTH-1:0]       upd_target,
    output logic                          upd_ready,
    input  logic                          wr_hold,
    output logic                          wr_en,
    output ADDR                           wr_pc,
    output ADDR                           wr_target,
    output logic [$clog2(QUEUE_DEPTH):0]  count,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    BTB_UPDATE_ENTRY            mem      [QUEUE_DEPTH];
    BTB_UPDATE_ENTRY            mem_next [QUEUE_DEPTH];
    ADDR                        mem_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic                       head_valid;
    logic                       pop;
    logic [QUEUE_DEPTH-1:0]     occ_mask;
    logic [QUEUE_DEPTH-1:0]     match_mask;
    logic [UPDATE_WIDTH-1:0]    survive;
    logic [UPDATE_WIDTH-1:0]    lane_hit;
    logic [PTR_W-1:0]           lane_idx [UPDATE_WIDTH];
    logic [CNT_W-1:0]           free_slots;
    logic [CNT_W-1:0]           enq_cnt;
    logic                       ovf_set;

    // Drain port; gated by reset so no write escapes in the reset cycle
    always_comb begin
        head_valid = reset && (count != '0);
        wr_en      = head_valid && !wr_hold;
        wr_pc      = head_valid ? mem[head].pc     : '0;
        wr_target  = head_valid ? mem[head].target : '0;
        pop        = wr_en;
        upd_ready  = !reset ||
                     ((CNT_W'(QUEUE_DEPTH) - count) >= CNT_W'(UPDATE_WIDTH));
    end

    // Occupancy from head/count; the popping head is excluded from coalescing
    always_comb begin
        for (int unsigned j = 0; j < QUEUE_DEPTH; j++) begin
            mem_pc[j]     = mem[j].pc;
            occ_mask[j]   = {1'b0, PTR_W'(j) - head} < count;
            match_mask[j] = occ_mask[j] && !(pop && (PTR_W'(j) == head));
        end
    end

    // Intra-group dedup: a lane is dropped if any higher valid lane has its PC
    always_comb begin
        for (int unsigned i = 0; i < UPDATE_WIDTH; i++) begin
            survive[i] = upd_valid[i];
            for (int unsigned k = i + 1; k < UPDATE_WIDTH; k++) begin
                if (upd_valid[k] && (upd_pc[k] == upd_pc[i])) begin
                    survive[i] = 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < UPDATE_WIDTH; g++) begin : g_match
        btb_upd_match #(
            .DEPTH(QUEUE_DEPTH)
        ) u_match (
            .entry_pc   (mem_pc),
            .valid_mask (match_mask),
            .lookup_pc  (upd_pc[g]),
            .hit        (lane_hit[g]),
            .hit_idx    (lane_idx[g])
        );
    end

    // Coalesce hits in place, allocate tail slots in lane order, flag drops.
    // Free slots credit the same-cycle pop, so at full-with-pop the tail
    // write lands on the departing head slot, which no lane may coalesce into.
    always_comb begin
        mem_next   = mem;
        enq_cnt    = '0;
        ovf_set    = 1'b0;
        free_slots = CNT_W'(QUEUE_DEPTH) - count + CNT_W'(pop);
        for (int unsigned i = 0; i < UPDATE_WIDTH; i++) begin
            if (survive[i]) begin
                if (lane_hit[i]) begin
                    mem_next[lane_idx[i]].target = upd_target[i];
                end else if (enq_cnt < free_slots) begin
                    mem_next[tail + PTR_W'(enq_cnt)] = '{pc: upd_pc[i], target: upd_target[i]};
                    enq_cnt = enq_cnt + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
    end

    // Queue storage; contents are masked by count so no reset is needed
    always_ff @(posedge clock) begin
        mem <= mem_next;
    end

    // Pointer, occupancy and sticky overflow state
    always_ff @(posedge clock) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(enq_cnt);
            count <= count + enq_cnt - CNT_W'(pop);
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: scoreboard of expected BTB writes.
module tb_btb_update_ctrl;
    import btb_update_ctrl_pkg::*;

    logic            clock;
    logic            reset;
    logic [1:0]      upd_valid;
    ADDR  [1:0]      upd_pc;
    ADDR  [1:0]      upd_target;
    logic            upd_ready;
    logic            wr_hold;
    logic            wr_en;
    ADDR             wr_pc;
    ADDR             wr_target;
    logic [3:0]      count;
    logic            overflow;

    int checks;
    int errors;
    BTB_UPDATE_ENTRY sb[$];

    btb_update_ctrl #(
        .QUEUE_DEPTH  (8),
        .UPDATE_WIDTH (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_ready  (upd_ready),
        .wr_hold    (wr_hold),
        .wr_en      (wr_en),
        .wr_pc      (wr_pc),
        .wr_target  (wr_target),
        .count      (count),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input ADDR p0, input ADDR t0,
                         input ADDR p1, input ADDR t1);
        upd_valid     = v;
        upd_pc[0]     = p0;
        upd_target[0] = t0;
        upd_pc[1]     = p1;
        upd_target[1] = t1;
    endtask

    task automatic idle();
        upd_valid = '0;
    endtask

    task automatic expect_wr(input ADDR p, input ADDR t);
        BTB_UPDATE_ENTRY e;
        e.pc     = p;
        e.target = t;
        sb.push_back(e);
    endtask

    // Every BTB write must match the oldest outstanding expectation
    task automatic monitor();
        BTB_UPDATE_ENTRY e;
        forever begin
            @(negedge clock);
            if (wr_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got pc=%h target=%h required no write", wr_pc, wr_target);
                end else begin
                    e = sb.pop_front();
                    if ({wr_pc, wr_target} !== {e.pc, e.target}) begin
                        errors++;
                        $display("FAIL write_order got pc=%h target=%h required pc=%h target=%h",
                                 wr_pc, wr_target, e.pc, e.target);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending required 0", sb.size());
        end
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL drain_count got %0d required 0", count);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({wr_en, wr_pc, wr_target, count, overflow, upd_ready} !== {1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got wr_en=%b pc=%h tgt=%h count=%0d ovf=%b rdy=%b required 0 0 0 0 0 1",
                     wr_en, wr_pc, wr_target, count, overflow, upd_ready);
        end
    endtask

    task automatic test_single();
        drive(2'b01, 32'h100, 32'h200, 32'h0, 32'h0);
        expect_wr(32'h100, 32'h200);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass got wr_en=%b required 0", wr_en);
        end
        step();
        idle();
        checks++;
        if ({wr_en, wr_pc, wr_target} !== {1'b1, 32'h100, 32'h200}) begin
            errors++;
            $display("FAIL single_write got en=%b pc=%h tgt=%h required 1 100 200", wr_en, wr_pc, wr_target);
        end
        step();
        checks++;
        if ({wr_en, count} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL single_after got en=%b count=%0d required 0 0", wr_en, count);
        end
    endtask

    task automatic test_dual();
        drive(2'b11, 32'h104, 32'h300, 32'h108, 32'h400);
        expect_wr(32'h104, 32'h300);
        expect_wr(32'h108, 32'h400);
        step();
        idle();
        checks++;
        if ({count, wr_pc} !== {4'd2, 32'h104}) begin
            errors++;
            $display("FAIL dual_first got count=%0d pc=%h required 2 104", count, wr_pc);
        end
        step();
        checks++;
        if ({count, wr_pc} !== {4'd1, 32'h108}) begin
            errors++;
            $display("FAIL dual_second got count=%0d pc=%h required 1 108", count, wr_pc);
        end
        wait_drain(10);
    endtask

    task automatic test_dedup();
        drive(2'b11, 32'h10C, 32'h500, 32'h10C, 32'h600);
        expect_wr(32'h10C, 32'h600);
        step();
        idle();
        checks++;
        if ({count, overflow} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL dedup_count got count=%0d ovf=%b required 1 0", count, overflow);
        end
        wait_drain(10);
    endtask

    task automatic test_coalesce_hold();
        wr_hold = 1'b1;
        drive(2'b01, 32'h110, 32'h700, 32'h0, 32'h0);
        step();
        drive(2'b01, 32'h110, 32'h800, 32'h0, 32'h0);
        step();
        idle();
        checks++;
        if ({count, wr_en} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL coalesce_count got count=%0d en=%b required 1 0", count, wr_en);
        end
        step();
        checks++;
        if (wr_target !== 32'h800) begin
            errors++;
            $display("FAIL coalesce_target got %h required 800", wr_target);
        end
        expect_wr(32'h110, 32'h800);
        wr_hold = 1'b0;
        wait_drain(10);
    endtask

    task automatic test_head_match();
        wr_hold = 1'b1;
        drive(2'b11, 32'h120, 32'hA00, 32'h124, 32'hA04);
        step();
        wr_hold = 1'b0;
        drive(2'b11, 32'h120, 32'hB00, 32'h124, 32'hB04);
        expect_wr(32'h120, 32'hA00);
        expect_wr(32'h124, 32'hB04);
        expect_wr(32'h120, 32'hB00);
        step();
        idle();
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL head_match_count got %0d required 2", count);
        end
        wait_drain(10);
    endtask

    task automatic fill_held();
        wr_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 32'h1000 + 32'(k * 16), 32'h2000 + 32'(k * 16),
                         32'h1008 + 32'(k * 16), 32'h2008 + 32'(k * 16));
            expect_wr(32'h1000 + 32'(k * 16), 32'h2000 + 32'(k * 16));
            expect_wr(32'h1008 + 32'(k * 16), 32'h2008 + 32'(k * 16));
            step();
        end
        idle();
    endtask

    task automatic test_fill_overflow();
        fill_held();
        checks++;
        if ({count, upd_ready, overflow} !== {4'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fill_full got count=%0d rdy=%b ovf=%b required 8 0 0", count, upd_ready, overflow);
        end
        drive(2'b11, 32'h1F00, 32'h2F00, 32'h1F08, 32'h2F08);
        step();
        idle();
        checks++;
        if ({count, overflow} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL fill_overflow got count=%0d ovf=%b required 8 1", count, overflow);
        end
        wr_hold = 1'b0;
        wait_drain(20);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got %b required 1", overflow);
        end
    endtask

    task automatic test_full_pop();
        apply_reset();
        fill_held();
        wr_hold = 1'b0;
        drive(2'b11, 32'h3000, 32'h4000, 32'h3008, 32'h4008);
        expect_wr(32'h3000, 32'h4000);
        step();
        idle();
        checks++;
        if ({count, overflow} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL full_pop got count=%0d ovf=%b required 8 1", count, overflow);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid_drain();
        wr_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive((k == 3) ? 2'b01 : 2'b11, 32'h5000 + 32'(k * 16), 32'h6000 + 32'(k * 16),
                  32'h5008 + 32'(k * 16), 32'h6008 + 32'(k * 16));
            step();
        end
        idle();
        expect_wr(32'h5000, 32'h6000);
        expect_wr(32'h5008, 32'h6008);
        wr_hold = 1'b0;
        step();
        step();
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL mid_drain_count got %0d required 5", count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle_write got wr_en=%b required 0", wr_en);
        end
        step();
        reset = 1'b1;
        checks++;
        if ({wr_en, count, overflow, upd_ready} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_drain_reset got en=%b count=%0d ovf=%b rdy=%b required 0 0 0 1",
                     wr_en, count, overflow, upd_ready);
        end
        repeat (10) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_drain_pending got %0d required 0", sb.size());
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        wr_hold   = 1'b0;
        upd_valid = '0;
        upd_pc    = '0;
        upd_target = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_dual();
        test_dedup();
        test_coalesce_hold();
        test_head_match();
        test_fill_overflow();
        test_full_pop();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
